// File: rtl/tagged_sram_array_pkg.sv
// Shared FSM state type and default geometry for the tagged SRAM array.
package sram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   localparam int unsigned DEPTH_DEF  = 16;
   localparam int unsigned TAG_W_DEF  = 4;
   localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/tagged_sram_array_if.sv
// Request/response bundle between a requester and the tagged SRAM array.
interface tagged_sram_array_if
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              req_valid;
   logic              we;
   logic [DEPTH-1:0]  wl;
   logic [TAG_W-1:0]  tag_in;
   logic [DATA_W-1:0] data_in;
   logic              flush;
   logic              busy;
   logic              rd_valid;
   logic [TAG_W-1:0]  tag_out;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              hit;
   logic              wl_err;

   modport master (
      output req_valid, we, wl, tag_in, data_in, flush,
      input  busy, rd_valid, tag_out, data_out, valid_out, hit, wl_err
   );

   modport slave (
      input  req_valid, we, wl, tag_in, data_in, flush,
      output busy, rd_valid, tag_out, data_out, valid_out, hit, wl_err
   );

endinterface

// File: rtl/tagged_sram_array_onehot_enc.sv
// Wordline decoder: binary index of a one-hot wordline plus a one-hot check.
module onehot_enc #(
   parameter int unsigned DEPTH = 16
) (
   input  logic [DEPTH-1:0]         wl,
   output logic [$clog2(DEPTH)-1:0] idx_c,
   output logic                     is_onehot_c
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   // OR of set-bit positions; only meaningful when exactly one bit is set
   always_comb begin
      idx_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (wl[i]) idx_c = idx_c | ADDR_W'(i);
      end
   end

   assign is_onehot_c = (wl != '0) && ((wl & (wl - DEPTH'(1))) == '0);

endmodule

// File: rtl/tagged_sram_array.sv
// Wordline-addressed tag/data array with per-entry valid bits, tag compare
// on read and a one-entry-per-cycle invalidate sweep.
module tagged_sram_array
   import sram_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   tagged_sram_array_if.slave  bus
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                accept, clr_en, wr_en;
   logic [DEPTH-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_mem  [DEPTH];
   logic [DATA_W-1:0]   data_mem [DEPTH];
   logic [ADDR_W-1:0]   enc_idx;
   logic                enc_ok;

   logic                rd_valid_q, valid_out_q, hit_q, wl_err_q;
   logic [TAG_W-1:0]    tag_out_q;
   logic [DATA_W-1:0]   data_out_q;

   onehot_enc #(.DEPTH(DEPTH)) u_enc (
      .wl          (bus.wl),
      .idx_c       (enc_idx),
      .is_onehot_c (enc_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Flush wins over a same-cycle request; everything is ignored while sweeping
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      accept  = 1'b0;
      clr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d = FLUSH;
               idx_d   = '0;
            end else begin
               accept = bus.req_valid;
            end
         end
         FLUSH: begin
            clr_en = 1'b1;
            idx_d  = idx_q + ADDR_W'(1);
            if (idx_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_en = accept && bus.we && enc_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (clr_en) begin
         valid_q[idx_q] <= 1'b0;
      end else if (wr_en) begin
         valid_q[enc_idx] <= 1'b1;
      end
   end

   // Tag/data storage carries no reset and survives flushes
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[enc_idx]  <= bus.tag_in;
         data_mem[enc_idx] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q  <= 1'b0;
         wl_err_q    <= 1'b0;
         valid_out_q <= 1'b0;
         hit_q       <= 1'b0;
         tag_out_q   <= '0;
         data_out_q  <= '0;
      end else begin
         rd_valid_q <= accept;
         wl_err_q   <= 1'b0;
         if (accept) begin
            if (!enc_ok) begin
               wl_err_q    <= 1'b1;
               valid_out_q <= 1'b0;
               hit_q       <= 1'b0;
               tag_out_q   <= '0;
               data_out_q  <= '0;
            end else if (bus.we) begin
               valid_out_q <= 1'b1;
               hit_q       <= 1'b1;
               tag_out_q   <= bus.tag_in;
               data_out_q  <= bus.data_in;
            end else begin
               valid_out_q <= valid_q[enc_idx];
               hit_q       <= valid_q[enc_idx] && (tag_mem[enc_idx] == bus.tag_in);
               tag_out_q   <= tag_mem[enc_idx];
               data_out_q  <= data_mem[enc_idx];
            end
         end
      end
   end

   assign bus.busy      = (state_q == FLUSH);
   assign bus.rd_valid  = rd_valid_q;
   assign bus.wl_err    = wl_err_q;
   assign bus.valid_out = valid_out_q;
   assign bus.hit       = hit_q;
   assign bus.tag_out   = tag_out_q;
   assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_tagged_sram_array.sv
// Randomized self-checking bench for tagged_sram_array against an array-level model.
module tb_tagged_sram_array;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned DATA_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   tagged_sram_array_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   tagged_sram_array #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: array contents, remaining flush cycles, expected outputs
   logic              m_valid [DEPTH];
   logic [TAG_W-1:0]  m_tag   [DEPTH];
   logic [DATA_W-1:0] m_data  [DEPTH];
   logic              m_known [DEPTH];
   int                flush_left = 0;

   logic              e_rv = 1'b0, e_err = 1'b0, e_vo = 1'b0, e_hit = 1'b0, e_known = 1'b1;
   logic [TAG_W-1:0]  e_tag = '0;
   logic [DATA_W-1:0] e_data = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_outputs();
      check("busy",      32'(bus.busy),      32'(flush_left > 0));
      check("rd_valid",  32'(bus.rd_valid),  32'(e_rv));
      check("wl_err",    32'(bus.wl_err),    32'(e_err));
      check("valid_out", 32'(bus.valid_out), 32'(e_vo));
      check("hit",       32'(bus.hit),       32'(e_hit));
      if (e_known) begin
         check("tag_out",  32'(bus.tag_out),  32'(e_tag));
         check("data_out", 32'(bus.data_out), 32'(e_data));
      end
   endtask

   // One clock: drive at negedge, model the edge, compare 1 time unit after it
   task automatic step(input logic rv, input logic w, input logic [DEPTH-1:0] wlv,
                       input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d, input logic fl);
      int a;
      bus.req_valid = rv;
      bus.we        = w;
      bus.wl        = wlv;
      bus.tag_in    = t;
      bus.data_in   = d;
      bus.flush     = fl;
      @(posedge clk);
      e_rv  = 1'b0;
      e_err = 1'b0;
      if (flush_left > 0) begin
         m_valid[DEPTH - flush_left] = 1'b0;
         flush_left--;
      end else if (fl) begin
         flush_left = DEPTH;
      end else if (rv) begin
         e_rv = 1'b1;
         if ($countones(wlv) != 1) begin
            e_err = 1'b1; e_vo = 1'b0; e_hit = 1'b0;
            e_tag = '0; e_data = '0; e_known = 1'b1;
         end else begin
            a = 0;
            for (int i = 0; i < int'(DEPTH); i++) if (wlv[i]) a = i;
            if (w) begin
               m_valid[a] = 1'b1; m_tag[a] = t; m_data[a] = d; m_known[a] = 1'b1;
               e_vo = 1'b1; e_hit = 1'b1; e_tag = t; e_data = d; e_known = 1'b1;
            end else begin
               e_vo = m_valid[a];
               e_hit = m_valid[a] && (m_tag[a] == t);
               e_tag = m_tag[a]; e_data = m_data[a]; e_known = m_known[a];
            end
         end
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   function automatic logic [DEPTH-1:0] onehot(input int i);
      return DEPTH'(1) << i;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
      flush_left = 0;
      e_rv = 1'b0; e_err = 1'b0; e_vo = 1'b0; e_hit = 1'b0;
      e_tag = '0; e_data = '0; e_known = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_valid[i] = 1'b0; m_known[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
      bus.req_valid = 1'b0; bus.we = 1'b0; bus.wl = '0;
      bus.tag_in = '0; bus.data_in = '0; bus.flush = 1'b0;
      #12;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Read of an empty entry after reset
      step(1'b1, 1'b0, 16'h0001, 4'h3, 8'h00, 1'b0);
      idle();

      // Write then tag-compare hit and miss
      step(1'b1, 1'b1, 16'h0020, 4'hA, 8'h5C, 1'b0);
      step(1'b1, 1'b0, 16'h0020, 4'hA, 8'h00, 1'b0);
      step(1'b1, 1'b0, 16'h0020, 4'hB, 8'h00, 1'b0);

      // Back-to-back write/read of top entry
      step(1'b1, 1'b1, 16'h8000, 4'h7, 8'hFF, 1'b0);
      step(1'b1, 1'b0, 16'h8000, 4'h7, 8'h00, 1'b0);
      idle();

      // Multi-hot and zero wordlines must not disturb the array
      step(1'b1, 1'b1, 16'h0001, 4'h1, 8'h11, 1'b0);
      step(1'b1, 1'b1, 16'h0002, 4'h2, 8'h22, 1'b0);
      step(1'b1, 1'b1, 16'h0003, 4'hE, 8'hEE, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 4'h1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 16'h0001, 4'h1, 8'h00, 1'b0);
      step(1'b1, 1'b0, 16'h0002, 4'h2, 8'h00, 1'b0);
      idle();

      // Fill, flush with a colliding read, requests during sweep, then read back
      for (int i = 0; i < int'(DEPTH); i++)
         step(1'b1, 1'b1, onehot(i), TAG_W'($urandom), DATA_W'($urandom), 1'b0);
      step(1'b1, 1'b0, 16'h0004, 4'h0, 8'h00, 1'b1);
      for (int i = 0; i < int'(DEPTH); i++)
         step(1'($urandom), 1'($urandom), onehot(i), 4'h5, 8'hA5, 1'($urandom));
      for (int i = 0; i < int'(DEPTH); i++)
         step(1'b1, 1'b0, onehot(i), m_tag[i], 8'h00, 1'b0);

      // Reset asserted in the middle of a sweep
      for (int i = 0; i < int'(DEPTH); i++)
         step(1'b1, 1'b1, onehot(i), TAG_W'($urandom), DATA_W'($urandom), 1'b0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < 5; i++) idle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++)
         step(1'b1, 1'b0, onehot(i), m_tag[i], 8'h00, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [DEPTH-1:0] w;
         if ($urandom_range(0, 9) == 0) w = DEPTH'($urandom);
         else w = onehot(int'($urandom_range(0, DEPTH - 1)));
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), w,
              TAG_W'($urandom_range(0, 3)), DATA_W'($urandom),
              1'($urandom_range(0, 39) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
